// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and the MIPS-subset datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             run;
    logic             step;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_source;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             halted;
    logic [1:0]       fault;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, zero, mem_ready, run, step,
        output pc_write, pc_write_cond, pc_source, ir_write, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               halted, fault, state_dbg, instr_count
    );

    modport slave (
        output opcode, funct, zero, mem_ready, run, step,
        input  pc_write, pc_write_cond, pc_source, ir_write, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               halted, fault, state_dbg, instr_count
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the MIPS-subset datapath: fetch/decode/execute sequencing,
// memory-ready handshake with timeout, run/single-step and halt on fault.
//
// state  | meaning
// FETCH  | 0  instruction read from ROM (idle while stopped)
// DECODE | 1  branch target precompute, opcode dispatch
// MEMADR | 2  lw/sw address calculation
// MEMRD  | 3  DataMemory read, waiting for mem_ready
// MEMWB  | 4  load result to RegisterFile
// MEMWR  | 5  DataMemory write, waiting for mem_ready
// EXEC   | 6  R-type ALU operation
// RWB    | 7  R-type result to rd
// BRANCH | 8  beq compare and conditional PC load
// JUMP   | 9  j target load
// ADDIEX | 10 addi ALU operation
// ADDIWB | 11 addi result to rt
// HALT   | 15 illegal opcode or memory timeout; reset only
module multicycle_ctrl #(
    parameter int TIMEOUT_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctl_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    // Last count value before the limit: the waiting cycle seen here is number 2**W-1.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    function automatic ctl_t f_ctl(input state_t s, input logic go);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = go;
                c.alu_src_b = go ? 2'd1 : 2'd0;
            end
            S_DECODE: c.alu_src_b = 2'd3;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
            end
            S_MEMRD:  c.mem_read  = 1'b1;
            S_MEMWR:  c.mem_write = 1'b1;
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'd2;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'd1;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'd1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'd2;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t               r_state;
    state_t               w_next;
    ctl_t                 r_ctl;
    logic [TIMEOUT_W-1:0] r_wait;
    logic [1:0]           r_fault;
    logic [1:0]           w_fault_next;
    logic                 r_halted;
    logic [CNT_W-1:0]     r_count;

    logic w_req;
    logic w_done;
    logic w_timeout;
    logic w_go;
    logic w_terminal;
    logic w_fetch_done;

    assign w_req        = r_ctl.mem_read | r_ctl.mem_write;
    assign w_done       = w_req & bus.mem_ready;
    assign w_timeout    = w_req & ~bus.mem_ready & (r_wait == WAIT_LAST);
    assign w_fetch_done = (r_state == S_FETCH) & w_done;
    // A started fetch is held until it completes, even if run drops or step was a pulse.
    assign w_go         = ((r_state == S_FETCH) & r_ctl.mem_read) | bus.run | bus.step;
    assign w_terminal   = (r_state == S_MEMWB) | (r_state == S_MEMWR) | (r_state == S_RWB) |
                          (r_state == S_BRANCH) | (r_state == S_JUMP) | (r_state == S_ADDIWB);

    always_comb begin
        w_next       = r_state;
        w_fault_next = r_fault;
        case (r_state)
            S_FETCH: begin
                if (w_done) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next       = S_HALT;
                    w_fault_next = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default: begin
                        w_next       = S_HALT;
                        w_fault_next = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD, S_MEMWR: begin
                if (w_done) begin
                    w_next = (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (w_timeout) begin
                    w_next       = S_HALT;
                    w_fault_next = FAULT_TIMEOUT;
                end
            end
            S_EXEC:   w_next = S_RWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_ctl    <= '0;
            r_wait   <= '0;
            r_fault  <= '0;
            r_halted <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_next;
            r_ctl    <= f_ctl(w_next, w_go);
            r_fault  <= w_fault_next;
            r_halted <= (w_next == S_HALT);
            r_wait   <= ((w_next == r_state) && w_req) ? r_wait + 1'b1 : '0;
            if (w_terminal && (w_next == S_FETCH)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.pc_write      = r_ctl.pc_write | w_fetch_done;
    assign bus.ir_write      = w_fetch_done;
    assign bus.pc_write_cond = r_ctl.pc_write_cond;
    assign bus.pc_source     = r_ctl.pc_source;
    assign bus.mem_read      = r_ctl.mem_read;
    assign bus.mem_write     = r_ctl.mem_write;
    assign bus.reg_write     = r_ctl.reg_write;
    assign bus.reg_dst       = r_ctl.reg_dst;
    assign bus.mem_to_reg    = r_ctl.mem_to_reg;
    assign bus.alu_src_a     = r_ctl.alu_src_a;
    assign bus.alu_src_b     = r_ctl.alu_src_b;
    assign bus.alu_op        = r_ctl.alu_op;
    assign bus.halted        = r_halted;
    assign bus.fault         = r_fault;
    assign bus.state_dbg     = r_state;
    assign bus.instr_count   = r_count;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, memory wait,
// single-step, timeout, illegal opcode and asynchronous reset against hand-computed values.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_wait;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(16)) bus ();

    multicycle_ctrl #(
        .TIMEOUT_W(4),
        .CNT_W    (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input int exp);
        chk(tag, int'(bus.state_dbg), exp);
    endtask

    initial begin
        bus.opcode    = 6'h00;
        bus.funct     = 6'h20;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        bus.run       = 1'b1;
        bus.step      = 1'b0;

        // held in reset
        #12;
        chk_st("rst_state", 0);
        chk("rst_mem_read", int'(bus.mem_read), 0);
        chk("rst_pc_write", int'(bus.pc_write), 0);
        chk("rst_halted", int'(bus.halted), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_count", int'(bus.instr_count), 0);
        reset = 1'b1;

        // R-type add
        cyc();
        chk_st("r_fetch", 0);
        chk("r_fetch_mem_read", int'(bus.mem_read), 1);
        chk("r_fetch_ir_write", int'(bus.ir_write), 1);
        chk("r_fetch_pc_write", int'(bus.pc_write), 1);
        chk("r_fetch_srcb", int'(bus.alu_src_b), 1);
        chk("r_fetch_count", int'(bus.instr_count), 0);
        cyc();
        chk_st("r_decode", 1);
        chk("r_decode_srcb", int'(bus.alu_src_b), 3);
        cyc();
        chk_st("r_exec", 6);
        chk("r_exec_aluop", int'(bus.alu_op), 2);
        chk("r_exec_srca", int'(bus.alu_src_a), 1);
        cyc();
        chk_st("r_rwb", 7);
        chk("r_rwb_reg_write", int'(bus.reg_write), 1);
        chk("r_rwb_reg_dst", int'(bus.reg_dst), 1);
        chk("r_rwb_mem_to_reg", int'(bus.mem_to_reg), 0);
        bus.opcode = 6'h23;
        cyc();
        chk_st("r_retired", 0);
        chk("r_count", int'(bus.instr_count), 1);

        // lw with three wait cycles in MEMRD
        cyc();
        chk_st("lw_decode", 1);
        cyc();
        chk_st("lw_memadr", 2);
        chk("lw_memadr_srcb", int'(bus.alu_src_b), 2);
        bus.mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk_st("lw_wait_state", 3);
            chk("lw_wait_mem_read", int'(bus.mem_read), 1);
            cyc();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk_st("lw_memrd_ready", 3);
        cyc();
        chk_st("lw_memwb", 4);
        chk("lw_memwb_reg_write", int'(bus.reg_write), 1);
        chk("lw_memwb_mem_to_reg", int'(bus.mem_to_reg), 1);
        chk("lw_memwb_reg_dst", int'(bus.reg_dst), 0);
        bus.opcode = 6'h04;
        bus.zero   = 1'b1;
        cyc();
        chk_st("lw_retired", 0);
        chk("lw_count", int'(bus.instr_count), 2);

        // beq
        cyc();
        cyc();
        chk_st("beq_branch", 8);
        chk("beq_pwc", int'(bus.pc_write_cond), 1);
        chk("beq_pc_source", int'(bus.pc_source), 1);
        chk("beq_aluop", int'(bus.alu_op), 1);
        chk("beq_pc_write", int'(bus.pc_write), 0);
        bus.opcode = 6'h02;
        cyc();
        chk("beq_count", int'(bus.instr_count), 3);

        // j
        cyc();
        cyc();
        chk_st("j_jump", 9);
        chk("j_pc_write", int'(bus.pc_write), 1);
        chk("j_pc_source", int'(bus.pc_source), 2);
        bus.opcode = 6'h2B;
        cyc();
        chk("j_count", int'(bus.instr_count), 4);

        // sw
        cyc();
        cyc();
        chk_st("sw_memadr", 2);
        cyc();
        chk_st("sw_memwr", 5);
        chk("sw_mem_write", int'(bus.mem_write), 1);
        chk("sw_mem_read", int'(bus.mem_read), 0);
        bus.opcode = 6'h08;
        cyc();
        chk_st("sw_retired", 0);
        chk("sw_count", int'(bus.instr_count), 5);

        // addi; run dropped mid-instruction
        cyc();
        cyc();
        chk_st("addi_ex", 10);
        chk("addi_ex_srcb", int'(bus.alu_src_b), 2);
        bus.run = 1'b0;
        cyc();
        chk_st("addi_wb", 11);
        chk("addi_wb_reg_write", int'(bus.reg_write), 1);
        chk("addi_wb_reg_dst", int'(bus.reg_dst), 0);
        cyc();
        chk_st("stop_state", 0);
        chk("stop_mem_read", int'(bus.mem_read), 0);
        chk("addi_count", int'(bus.instr_count), 6);
        cyc();
        cyc();
        chk_st("idle_state", 0);
        chk("idle_mem_read", int'(bus.mem_read), 0);
        chk("idle_count", int'(bus.instr_count), 6);

        // single step of an R-type
        bus.opcode = 6'h00;
        bus.step   = 1'b1;
        cyc();
        bus.step = 1'b0;
        #1;
        chk_st("step_fetch", 0);
        chk("step_mem_read", int'(bus.mem_read), 1);
        cyc();
        chk_st("step_decode", 1);
        cyc();
        cyc();
        chk_st("step_rwb", 7);
        cyc();
        chk("step_count", int'(bus.instr_count), 7);
        chk("step_stop_mem_read", int'(bus.mem_read), 0);
        cyc();
        chk_st("step_idle_state", 0);
        chk("step_idle_count", int'(bus.instr_count), 7);

        // fetch timeout
        bus.run       = 1'b1;
        bus.mem_ready = 1'b0;
        cyc();
        n_wait = 0;
        for (int k = 0; k < 40 && !bus.halted; k++) begin
            if (bus.state_dbg == 4'd0 && bus.mem_read) n_wait++;
            cyc();
        end
        chk("to_wait_cycles", n_wait, 15);
        chk("to_halted", int'(bus.halted), 1);
        chk("to_fault", int'(bus.fault), 2);
        chk_st("to_state", 15);
        chk("to_mem_read", int'(bus.mem_read), 0);
        bus.mem_ready = 1'b1;
        cyc();
        cyc();
        chk_st("to_hold_state", 15);
        chk("to_hold_fault", int'(bus.fault), 2);

        // reset out of HALT, then async reset during RWB
        reset = 1'b0;
        #3;
        chk_st("rst2_state", 0);
        chk("rst2_fault", int'(bus.fault), 0);
        chk("rst2_count", int'(bus.instr_count), 0);
        reset = 1'b1;
        cyc();
        cyc();
        cyc();
        cyc();
        chk_st("mid_rwb", 7);
        chk("mid_rwb_reg_write", int'(bus.reg_write), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_reg_write", int'(bus.reg_write), 0);
        chk_st("mid_rst_state", 0);
        #2;
        reset = 1'b1;

        // illegal opcode
        bus.opcode = 6'h3F;
        cyc();
        chk("ill_fetch_mem_read", int'(bus.mem_read), 1);
        cyc();
        chk_st("ill_decode", 1);
        cyc();
        chk_st("ill_halt", 15);
        chk("ill_halted", int'(bus.halted), 1);
        chk("ill_fault", int'(bus.fault), 1);
        chk("ill_mem_read", int'(bus.mem_read), 0);
        chk("ill_reg_write", int'(bus.reg_write), 0);
        chk("ill_pc_write", int'(bus.pc_write), 0);
        chk("ill_ir_write", int'(bus.ir_write), 0);
        repeat (3) cyc();
        chk_st("ill_hold_state", 15);
        chk("ill_hold_fault", int'(bus.fault), 1);
        chk("ill_count", int'(bus.instr_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
